// File: rtl/timer_scheduler_pkg.sv
// Shared definitions for the multi-channel timer scheduler: command opcodes
// and the per-channel state and mode encodings.
package timer_scheduler_pkg;

   // Command opcodes carried on cfg_op.
   localparam logic [1:0] OP_STOP      = 2'b00;
   localparam logic [1:0] OP_START_PER = 2'b01;
   localparam logic [1:0] OP_START_ONE = 2'b10;
   localparam logic [1:0] OP_SET_PER   = 2'b11;

   // A channel only counts base ticks while it is in RUN.
   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } ch_state_t;

   // A periodic channel reloads from its period on expiry; a one-shot channel
   // drops back to IDLE.
   typedef enum logic {
      MODE_PERIODIC = 1'b0,
      MODE_ONESHOT  = 1'b1
   } ch_mode_t;

endpackage : timer_scheduler_pkg

// File: rtl/tick_prescaler.sv
// Free-running prescaler shared by all timer channels. Emits a registered
// single-cycle tick once every PRESCALE clock cycles (PRESCALE must be >= 2).
module tick_prescaler #(
   parameter int PRESCALE = 10
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int            PW      = $clog2(PRESCALE);
   localparam logic [PW-1:0] PC_LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] pc;

   // Count 0..PRESCALE-1; tick is high for the cycle after pc reaches the last value.
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc   <= '0;
         tick <= 1'b0;
      end else begin
         tick <= (pc == PC_LAST);
         pc   <= (pc == PC_LAST) ? '0 : pc + PW'(1);
      end
   end

endmodule : tick_prescaler

// File: rtl/timer_scheduler.sv
// Multi-channel timer scheduler. One shared prescaler produces base_tick;
// NCH countdown channels turn it into single-cycle expiry pulses, each
// configured through a valid/ready command port for periodic or one-shot use.
module timer_scheduler
   import timer_scheduler_pkg::*;
#(
   parameter int  CLK_HZ  = 100_000_000,
   parameter int  TICK_HZ = 1_000,
   parameter int  NCH     = 4,
   parameter int  CW      = 16,
   localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           cfg_valid,
   output logic           cfg_ready,
   input  logic [CHW-1:0] cfg_ch,
   input  logic [1:0]     cfg_op,
   input  logic [CW-1:0]  cfg_period,
   output logic           base_tick,
   output logic [NCH-1:0] ch_pulse,
   output logic [NCH-1:0] ch_busy
);

   localparam int PRESCALE = CLK_HZ / TICK_HZ;

   logic          cmd_accept;
   logic [CW-1:0] load_period;

   assign cmd_accept = cfg_valid && cfg_ready;

   // A zero period would underflow the countdown, so it is loaded as 1.
   assign load_period = (cfg_period == '0) ? CW'(1) : cfg_period;

   tick_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .tick (base_tick)
   );

   // Ready comes up one cycle after reset and drops for one cycle after each accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cfg_ready <= 1'b0;
      end else begin
         cfg_ready <= !cmd_accept;
      end
   end

   for (genvar i = 0; i < NCH; i++) begin : g_ch

      ch_state_t     state_q, state_d;
      ch_mode_t      mode_q, mode_d;
      logic [CW-1:0] per_q, per_d;
      logic [CW-1:0] cnt_q, cnt_d;
      logic          pulse_q, pulse_d;
      logic          hit;

      // Selects of NCH or above match no channel and are dropped.
      assign hit = cmd_accept && (int'(cfg_ch) == i);

      // Next-state logic: an accepted command for this channel overrides a
      // coincident base_tick, so that tick is neither counted nor allowed to expire.
      // NOTE: every output of this block is given a default first, so no path
      // leaves a variable unassigned and no latch is inferred.
      always_comb begin
         state_d = state_q;
         mode_d  = mode_q;
         per_d   = per_q;
         cnt_d   = cnt_q;
         pulse_d = 1'b0;
         if (hit) begin
            case (cfg_op)
               OP_STOP: begin
                  state_d = IDLE;
               end
               OP_START_PER: begin
                  per_d   = load_period;
                  cnt_d   = load_period;
                  mode_d  = MODE_PERIODIC;
                  state_d = RUN;
               end
               OP_START_ONE: begin
                  per_d   = load_period;
                  cnt_d   = load_period;
                  mode_d  = MODE_ONESHOT;
                  state_d = RUN;
               end
               OP_SET_PER: begin
                  per_d = load_period;
               end
               default: begin
               end
            endcase
         end else if ((state_q == RUN) && base_tick) begin
            if (cnt_q == CW'(1)) begin
               pulse_d = 1'b1;
               if (mode_q == MODE_PERIODIC) begin
                  cnt_d = per_q;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
      end

      // Channel registers; the period and count reset to 1 so cnt never holds 0.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            state_q <= IDLE;
            mode_q  <= MODE_PERIODIC;
            per_q   <= CW'(1);
            cnt_q   <= CW'(1);
            pulse_q <= 1'b0;
         end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            per_q   <= per_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
         end
      end

      assign ch_pulse[i] = pulse_q;
      assign ch_busy[i]  = (state_q == RUN);

   end : g_ch

endmodule : timer_scheduler

// File: tb/tb_timer_scheduler.sv
// Directed bench for timer_scheduler with PRESCALE=10, NCH=4, CW=16.
// Cycle numbers count rising edges after reset release, starting at 1;
// outputs are sampled 1 time unit after each rising edge.
module tb_timer_scheduler;
   import timer_scheduler_pkg::*;

   localparam int NCH = 4;
   localparam int CW  = 16;

   logic           clk        = 1'b0;
   logic           rst        = 1'b1;
   logic           cfg_valid  = 1'b0;
   logic [1:0]     cfg_ch     = '0;
   logic [1:0]     cfg_op     = '0;
   logic [CW-1:0]  cfg_period = '0;
   logic           cfg_ready;
   logic           base_tick;
   logic [NCH-1:0] ch_pulse;
   logic [NCH-1:0] ch_busy;

   int checks = 0;
   int errors = 0;
   int cyc;

   typedef struct {
      int at;
      int chan;
   } pulse_ev_t;

   pulse_ev_t exp_q[$];

   timer_scheduler #(
      .CLK_HZ  (1000),
      .TICK_HZ (100),
      .NCH     (NCH),
      .CW      (CW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_ch     (cfg_ch),
      .cfg_op     (cfg_op),
      .cfg_period (cfg_period),
      .base_tick  (base_tick),
      .ch_pulse   (ch_pulse),
      .ch_busy    (ch_busy)
   );

   always #5 clk = ~clk;

   // Cycle counter: 0 while in reset, 1 at the first edge after release.
   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog cycle=%0d", cyc);
      $fatal(1, "simulation time limit reached");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   function automatic logic [NCH-1:0] exp_pulse_mask();
      logic [NCH-1:0] m;
      m = '0;
      foreach (exp_q[k]) begin
         if (exp_q[k].at == cyc) m[exp_q[k].chan] = 1'b1;
      end
      return m;
   endfunction

   task automatic expect_pulse(input int chan, input int at);
      pulse_ev_t ev;
      ev.at   = at;
      ev.chan = chan;
      exp_q.push_back(ev);
   endtask

   // One clock: base_tick must be high exactly in cycles 10, 20, ...; pulses
   // must match the hand-computed expectation list every cycle.
   task automatic step();
      @(posedge clk);
      #1;
      check("base_tick", 32'(base_tick), 32'((!rst) && (cyc > 0) && (cyc % 10 == 0)));
      check("ch_pulse", 32'(ch_pulse), 32'(exp_pulse_mask()));
   endtask

   task automatic run_to(input int c);
      while (cyc < c) step();
   endtask

   task automatic busy(input int exp);
      check("ch_busy", 32'(ch_busy), 32'(exp));
   endtask

   // Present a command in the current cycle; it is accepted at the next edge.
   task automatic send(input int chan, input logic [1:0] op, input int per);
      check("cfg_ready_before_cmd", 32'(cfg_ready), 1);
      cfg_valid  = 1'b1;
      cfg_ch     = 2'(chan);
      cfg_op     = op;
      cfg_period = CW'(per);
      step();
      cfg_valid  = 1'b0;
      check("cfg_ready_after_accept", 32'(cfg_ready), 0);
   endtask

   initial begin
      // Reset held for 5 cycles: all outputs low.
      repeat (5) begin
         step();
         busy(0);
         check("cfg_ready_in_reset", 32'(cfg_ready), 0);
      end
      rst = 1'b0;
      step();                                   // cycle 1
      check("cfg_ready_after_release", 32'(cfg_ready), 1);
      busy(0);
      run_to(21);

      // Periodic ch0, period 3, accepted at edge 22: ticks 30,40,50 -> pulse 51,
      // then every 30 cycles.
      expect_pulse(0, 51);
      expect_pulse(0, 81);
      expect_pulse(0, 111);
      send(0, OP_START_PER, 3);                 // cycle 22
      busy('h1);

      // One-shot ch1, period 2, accepted at 56: ticks 60,70 -> pulse 71.
      run_to(55);
      expect_pulse(1, 71);
      send(1, OP_START_ONE, 2);                 // cycle 56
      busy('h3);
      run_to(70);
      busy('h3);
      run_to(71);
      busy('h1);                                // busy falls in the pulse cycle

      // Periodic ch2 with period 0 (acts as 1), accepted at 76: pulse every tick.
      run_to(75);
      expect_pulse(2, 81);
      expect_pulse(2, 91);
      expect_pulse(2, 101);
      expect_pulse(2, 111);
      expect_pulse(2, 151);                     // after SET_PERIOD 4: ticks 120..150
      send(2, OP_START_PER, 0);                 // cycle 76
      busy('h5);
      run_to(103);
      send(2, OP_SET_PER, 4);                   // cycle 104, count of 1 completes at 111
      busy('h5);

      // Stop ch0 at 116.
      run_to(115);
      send(0, OP_STOP, 0);                      // cycle 116
      busy('h4);

      // Collision: ch3 one-shot period 1 accepted at edge 121 while base_tick is
      // high in cycle 120; that tick is skipped for ch3 -> pulse 131. ch2 still
      // counts tick 120 (its pulse at 151 depends on it).
      run_to(120);
      expect_pulse(3, 131);
      send(3, OP_START_ONE, 1);                 // cycle 121
      busy('hC);
      run_to(130);
      busy('hC);
      run_to(131);
      busy('h4);

      // Back-to-back valid: accept at 134, ignored at 135, accept at 136.
      run_to(133);
      check("cfg_ready_b2b_start", 32'(cfg_ready), 1);
      cfg_valid  = 1'b1;
      cfg_ch     = 2'd1;
      cfg_op     = OP_START_ONE;
      cfg_period = CW'(1);
      step();                                   // cycle 134
      check("cfg_ready_b2b_134", 32'(cfg_ready), 0);
      busy('h6);
      cfg_op     = OP_STOP;
      cfg_period = '0;
      step();                                   // cycle 135: not accepted
      check("cfg_ready_b2b_135", 32'(cfg_ready), 1);
      busy('h6);
      step();                                   // cycle 136: accepted
      check("cfg_ready_b2b_136", 32'(cfg_ready), 0);
      busy('h4);
      cfg_valid  = 1'b0;
      step();                                   // cycle 137
      check("cfg_ready_b2b_137", 32'(cfg_ready), 1);

      // Periodic ch0 period 1 at 144: pulses 151, 161; reset lands mid-cycle 161.
      run_to(143);
      expect_pulse(0, 151);
      expect_pulse(0, 161);
      send(0, OP_START_PER, 1);                 // cycle 144
      busy('h5);
      run_to(161);
      #2;
      rst = 1'b1;
      exp_q.delete();
      #1;
      check("pulse_async_reset", 32'(ch_pulse), 0);
      check("busy_async_reset", 32'(ch_busy), 0);
      check("ready_async_reset", 32'(cfg_ready), 0);
      check("tick_async_reset", 32'(base_tick), 0);
      repeat (3) step();
      rst = 1'b0;

      // After reset everything stays idle until restarted.
      run_to(62);
      busy(0);
      expect_pulse(1, 81);
      expect_pulse(1, 101);
      send(1, OP_START_PER, 2);                 // cycle 63: ticks 70,80 -> 81
      busy('h2);
      run_to(105);
      busy('h2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_timer_scheduler
